// File: rtl/coin_pkg.sv
// Shared coin codes and output-FSM state encoding for the coin intake stage.
package coin_pkg;

   localparam int unsigned CODE_W = 2;

   // FIFO payload codes; NONE never enters the queue.
   localparam logic [CODE_W-1:0] COIN_NONE = 2'b00;
   localparam logic [CODE_W-1:0] COIN_1    = 2'b01;
   localparam logic [CODE_W-1:0] COIN_5    = 2'b10;
   localparam logic [CODE_W-1:0] COIN_10   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/coin_intake_if.sv
// Sensor/button/busy inputs and pulse/status outputs of the coin intake stage.
// master: the side that drives the raw lines and busy (sensors + vending FSM).
// slave : the coin intake block itself.
interface coin_intake_if #(
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             s1;
   logic             s5;
   logic             s10;
   logic             btn_rest;
   logic             busy;
   logic             i1;
   logic             i5;
   logic             i10;
   logic             rest;
   logic             rej;
   logic [CNT_W-1:0] fifo_cnt;

   modport master (
      output s1, s5, s10, btn_rest, busy,
      input  i1, i5, i10, rest, rej, fifo_cnt
   );

   modport slave (
      input  s1, s5, s10, btn_rest, busy,
      output i1, i5, i10, rest, rej, fifo_cnt
   );

endinterface

// File: rtl/coin_debounce.sv
// Single-channel debouncer.
// Ports: clk, reset (async, active-high), raw (bouncing input),
//        filt (filtered level), rise (one-cycle pulse on filt 0->1).
module coin_debounce #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filt,
   output logic rise
);

   localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          raw_q;
   logic [CW-1:0] cnt;

   // raw_q samples the asynchronous line; filt follows it after DB_CYCLES agreeing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_q <= 1'b0;
         cnt   <= '0;
         filt  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         raw_q <= raw;
         rise  <= 1'b0;
         if (raw_q == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= raw_q;
            rise <= raw_q;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/coin_intake.sv
// Coin intake front end for the vending FSM: debounces coin sensors and the
// refund button, queues coins, and emits spaced single-cycle pulses.
// Ports: clk, reset (async, active-high),
//        bus.slave: s1/s5/s10/btn_rest/busy in; i1/i5/i10/rest/rej/fifo_cnt out.
module coin_intake
   import coin_pkg::*;
#(
   parameter int unsigned DB_CYCLES  = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   coin_intake_if.slave  bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   // Filtered levels are not needed here; only their rising edges are.
   logic [3:0] filt_unused;
   logic       rise1, rise5, rise10, rise_rest;

   coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
      .clk(clk), .reset(reset), .raw(bus.s1), .filt(filt_unused[0]), .rise(rise1));
   coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db5 (
      .clk(clk), .reset(reset), .raw(bus.s5), .filt(filt_unused[1]), .rise(rise5));
   coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db10 (
      .clk(clk), .reset(reset), .raw(bus.s10), .filt(filt_unused[2]), .rise(rise10));
   coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbr (
      .clk(clk), .reset(reset), .raw(bus.btn_rest), .filt(filt_unused[3]), .rise(rise_rest));

   logic              pend1, pend5, pend10, pend_rest;
   logic [CODE_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   state_t            state, next_state;

   logic              clr1_c, clr5_c, clr10_c;
   logic [CODE_W-1:0] sel_c;
   logic              push_c, rej_c;
   logic              pop_c, clr_rest_c;
   logic              i1_c, i5_c, i10_c, rest_c;

   // Enqueue arbiter: one pending coin per cycle, highest value first.
   // Fullness is judged on the pre-pop count.
   always_comb begin
      sel_c   = COIN_NONE;
      clr1_c  = 1'b0;
      clr5_c  = 1'b0;
      clr10_c = 1'b0;
      if (pend10) begin
         sel_c   = COIN_10;
         clr10_c = 1'b1;
      end else if (pend5) begin
         sel_c  = COIN_5;
         clr5_c = 1'b1;
      end else if (pend1) begin
         sel_c  = COIN_1;
         clr1_c = 1'b1;
      end
      push_c = (sel_c != COIN_NONE) && (count <  CW'(FIFO_DEPTH));
      rej_c  = (sel_c != COIN_NONE) && (count >= CW'(FIFO_DEPTH));
   end

   // Output FSM next state; coins are served before a pending refund.
   always_comb begin
      next_state = state;
      pop_c      = 1'b0;
      clr_rest_c = 1'b0;
      i1_c       = 1'b0;
      i5_c       = 1'b0;
      i10_c      = 1'b0;
      rest_c     = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.busy) begin
               if (count != '0) begin
                  next_state = EMIT;
                  pop_c      = 1'b1;
                  case (mem[rd_ptr])
                     COIN_1:  i1_c  = 1'b1;
                     COIN_5:  i5_c  = 1'b1;
                     COIN_10: i10_c = 1'b1;
                     default: ;
                  endcase
               end else if (pend_rest) begin
                  next_state = EMIT;
                  rest_c     = 1'b1;
                  clr_rest_c = 1'b1;
               end
            end
         end
         EMIT:    next_state = HOLD;
         HOLD:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State, pending flags, FIFO and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pend1     <= 1'b0;
         pend5     <= 1'b0;
         pend10    <= 1'b0;
         pend_rest <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= COIN_NONE;
         bus.i1    <= 1'b0;
         bus.i5    <= 1'b0;
         bus.i10   <= 1'b0;
         bus.rest  <= 1'b0;
         bus.rej   <= 1'b0;
      end else begin
         state     <= next_state;
         pend1     <= (pend1     & ~clr1_c)     | rise1;
         pend5     <= (pend5     & ~clr5_c)     | rise5;
         pend10    <= (pend10    & ~clr10_c)    | rise10;
         pend_rest <= (pend_rest & ~clr_rest_c) | rise_rest;
         if (push_c) begin
            mem[wr_ptr] <= sel_c;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_c) rd_ptr <= rd_ptr + 1'b1;
         count     <= count + CW'(push_c) - CW'(pop_c);
         bus.i1    <= i1_c;
         bus.i5    <= i5_c;
         bus.i10   <= i10_c;
         bus.rest  <= rest_c;
         bus.rej   <= rej_c;
      end
   end

   assign bus.fifo_cnt = count;

endmodule

// File: doc/coin_intake.md
Name: coin_intake

Overview:
- Front-end stage that feeds the 3-lei vending FSM.
- Cleans raw coin-sensor and refund-button lines, queues accepted coins in a small FIFO, and presents them downstream as mutually exclusive single-cycle pulses on i1/i5/i10/rest.
- Presents pulses only while the vending FSM is not busy returning change.
- Rejects coins through a gate pulse when the queue is full.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles required before a filtered level changes.
- FIFO_DEPTH, 4: coin queue entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- s1  in  1  raw 1-leu sensor, may bounce.
- s5  in  1  raw 5-lei sensor.
- s10  in  1  raw 10-lei sensor.
- btn_rest  in  1  raw refund button.
- busy  in  1  high while the downstream FSM is dispensing change; no pulse is issued while high.
- i1  out  1  one-cycle pulse: 1 leu inserted.
- i5  out  1  one-cycle pulse: 5 lei inserted.
- i10  out  1  one-cycle pulse: 10 lei inserted.
- rest  out  1  one-cycle pulse: refund request.
- rej  out  1  one-cycle pulse: coin diverted to return chute, queue full.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is asynchronous, active-high.
  - All outputs are registered. On reset: i1, i5, i10, rest, rej = 0; fifo_cnt = 0.
  - Reset also clears FIFO contents, pointers, filtered levels, pending flags and debounce counters, and puts the FSM in IDLE.
  - Reset mid-operation discards queued coins; no pulse is issued on reset exit.
- Debounce, per channel (s1, s5, s10, btn_rest):
  - Each channel has a filtered level f, initially 0, and a counter.
  - The counter increments while raw != f and clears when raw == f.
  - When the counter reaches DB_CYCLES-1 while raw != f, f toggles.
  - A rising edge of f sets that channel's pending flag.
  - Glitches shorter than DB_CYCLES cycles never change f.
- Enqueue arbiter, once per cycle:
  - Selects the highest-value pending coin, priority 10 > 5 > 1.
  - If pre-pop count < FIFO_DEPTH: write its code and clear its pending flag.
  - Otherwise: pulse rej for that cycle and clear its pending flag. Only one coin is rejected per cycle.
  - Other pending coins wait for later cycles.
  - A simultaneous pop does not free space for the same-cycle push.
- FIFO coding: 2-bit codes, 01 = 1 leu, 10 = 5 lei, 11 = 10 lei.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- Output FSM, states IDLE, EMIT, HOLD:
  - IDLE → EMIT when busy == 0 and count > 0: pop the head. During EMIT, exactly the one matching output is high for one cycle.
  - IDLE → EMIT when busy == 0, count == 0 and rest pending: rest high for one cycle; clear rest pending.
  - EMIT → HOLD unconditionally. HOLD lasts one cycle so the downstream FSM can assert busy.
  - HOLD → IDLE unconditionally.
  - Coins always take precedence over refund; a pending rest waits until the queue is empty.
- Spacing and latency:
  - At most one of i1/i5/i10/rest is high in any cycle; consecutive pulses are at least 3 cycles apart.
  - Latency: with FSM in IDLE, queue empty and busy = 0, a clean raw rising edge produces its output pulse DB_CYCLES+3 cycles after raw is first sampled high.
- busy handling: busy high in IDLE blocks emission, and coins keep queuing. busy is ignored in EMIT and HOLD.
- Re-triggering: raw held high produces one event only. A new event requires f to fall and rise again.

Decomposition:
- Package coin_pkg holds:
  - coin code constants: COIN_NONE = 00, COIN_1 = 01, COIN_5 = 10, COIN_10 = 11;
  - FSM state encoding: IDLE, EMIT, HOLD.
- One sub-module, coin_debounce: parameter DB_CYCLES; ports clk, reset, raw, filt, rise. Instantiated four times.
- FIFO and arbiter stay inline.

Test Plan:
- Clean s5 pulse of 10 cycles, busy = 0 → exactly one i5 pulse at cycle DB_CYCLES+3 = 7; fifo_cnt returns to 0; rej stays 0.
- s1 bounce of 1-2 cycle glitches, then 8 stable cycles → exactly one i1 pulse; glitches alone produce no output.
- s1 and s10 rise in the same cycle, busy = 0 → i10 pulse, then i1 pulse 3 cycles later.
- busy held 1 while 5 coins arrive (1, 5, 1, 10, 5) with DEPTH = 4 → fifo_cnt = 4 and one rej pulse on the fifth coin. After busy drops, the sequence is i1, i5, i1, i10, each 3 cycles apart.
- btn_rest pressed while 2 coins are queued, then busy released → both coin pulses first, then one rest pulse.
- reset asserted with fifo_cnt = 3 → all outputs 0 and fifo_cnt = 0 immediately (asynchronous). After release, no pulses appear without new input.
